// File: rtl/oob_write_filter_pkg.sv
// rtl/oob_write_filter_pkg.sv - shared types and constants for the out-of-range write filter
package oob_write_filter_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  localparam int             OOB_CNT_W   = 16;
  localparam logic [15:0]    OOB_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wreq_t;

endpackage

// File: rtl/oob_write_filter_fifo.sv
// rtl/oob_write_filter_fifo.sv - request buffer for the write filter
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module oob_write_filter_fifo
  import oob_write_filter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  wreq_t push_data_i,
  input  logic  pop_i,
  output wreq_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  wreq_t         mem_q [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/oob_write_filter.sv
// rtl/oob_write_filter.sv - range-checking write front end for a non-power-of-two array
// Define OOB_WRAP_EN to issue out-of-range writes at addr % DEPTH instead of dropping them.
module oob_write_filter
  import oob_write_filter_pkg::*;
#(
  parameter int DEPTH      = 7,
  parameter int AW         = ADDR_W,
  parameter int DW         = DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_addr,
  input  logic [DW-1:0]        in_data,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic                 oob_pulse,
  output logic [OOB_CNT_W-1:0] oob_count,
  output logic                 idle
);

  wreq_t                push_req;
  wreq_t                head;
  logic                 full, empty;
  logic                 head_legal;
  logic                 slot_free;
  logic                 pop;
  logic                 issue;
  logic                 oob_hit;
  logic [AW-1:0]        issue_addr;

  logic                 wr_valid_q, wr_valid_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [DW-1:0]        wr_data_q, wr_data_d;
  logic                 oob_pulse_q, oob_pulse_d;
  logic [OOB_CNT_W-1:0] oob_count_q, oob_count_d;

  assign push_req.addr = in_addr;
  assign push_req.data = in_data;

  oob_write_filter_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (in_valid),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Extend by one bit so DEPTH == 2**AW still compares correctly.
  assign head_legal = ({1'b0, head.addr} < (AW+1)'(DEPTH));
  assign slot_free  = !wr_valid_q || wr_ready;

`ifdef OOB_WRAP_EN
  assign pop        = !empty && slot_free;
  assign issue      = pop;
  assign issue_addr = head_legal ? head.addr : AW'(32'(head.addr) % 32'(DEPTH));
`else
  assign pop        = !empty && (slot_free || !head_legal);
  assign issue      = pop && head_legal;
  assign issue_addr = head.addr;
`endif

  assign oob_hit = pop && !head_legal;

  always_comb begin
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    oob_pulse_d = oob_hit;
    oob_count_d = oob_count_q;
    if (issue) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = issue_addr;
      wr_data_d  = head.data;
    end else if (wr_ready) begin
      wr_valid_d = 1'b0;
    end
    if (oob_hit && (oob_count_q != OOB_CNT_MAX)) oob_count_d = oob_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      oob_pulse_q <= 1'b0;
      oob_count_q <= '0;
    end else begin
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      oob_pulse_q <= oob_pulse_d;
      oob_count_q <= oob_count_d;
    end
  end

  assign in_ready  = !full;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign oob_pulse = oob_pulse_q;
  assign oob_count = oob_count_q;
  assign idle      = empty && !wr_valid_q;

endmodule

// File: tb/tb_oob_write_filter.sv
// tb/tb_oob_write_filter.sv - directed self-checking bench for oob_write_filter
module tb_oob_write_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [31:0] in_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        oob_pulse;
  logic [15:0] oob_count;
  logic        idle;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulse_cnt    = 0;

  logic [2:0]  log_addr [$];
  logic [31:0] log_data [$];

  always #5 clk = ~clk;

  oob_write_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .oob_pulse (oob_pulse),
    .oob_count (oob_count),
    .idle      (idle)
  );

  always @(posedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (rst_n && oob_pulse) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    pulse_cnt = 0;
  endtask

  task automatic push(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("push_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!idle && n < 200) begin
      step();
      n++;
    end
    step();
    check("drain_idle", 32'(idle), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [2:0] a, input logic [31:0] d);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
      check({tag, "_data"}, log_data[idx], d);
    end else begin
      check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    wr_ready = 1'b1;

    // Reset state
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_oob_pulse", 32'(oob_pulse), 32'd0);
    check("rst_oob_count", 32'(oob_count), 32'd0);
    step();
    rst_n = 1'b1;

    // 1: all legal addresses in order
    clear_log();
    for (int i = 0; i < 7; i++) push(3'(i), 32'(10 + i));
    drain();
    check("t1_count", 32'(log_addr.size()), 32'd7);
    for (int i = 0; i < 7; i++) check_log("t1", i, 3'(i), 32'(10 + i));
    check("t1_oob_count", 32'(oob_count), 32'd0);

    // 2: one out-of-range request, then a legal one
    clear_log();
    push(3'd7, 32'd99);
    push(3'd0, 32'd5);
    drain();
`ifdef OOB_WRAP_EN
    check("t2_count", 32'(log_addr.size()), 32'd2);
    check_log("t2_wrap", 0, 3'd0, 32'd99);
    check_log("t2", 1, 3'd0, 32'd5);
`else
    check("t2_count", 32'(log_addr.size()), 32'd1);
    check_log("t2", 0, 3'd0, 32'd5);
`endif
    check("t2_pulses", 32'(pulse_cnt), 32'd1);
    check("t2_oob_count", 32'(oob_count), 32'd1);

    // 3: backpressure fills FIFO plus output slot
    clear_log();
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3'(i), 32'(20 + i));
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    check("t3_wr_valid", 32'(wr_valid), 32'd1);
    check("t3_hold_addr", 32'(wr_addr), 32'd0);
    check("t3_hold_data", wr_data, 32'd20);
    step();
    check("t3_stable_data", wr_data, 32'd20);
    wr_ready = 1'b1;
    drain();
    check("t3_count", 32'(log_addr.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_log("t3", i, 3'(i), 32'(20 + i));

    // 4: interleaved legal and illegal
    do_reset();
    clear_log();
    push(3'd1, 32'd30);
    push(3'd7, 32'd31);
    push(3'd2, 32'd32);
    push(3'd7, 32'd33);
    push(3'd3, 32'd34);
    drain();
`ifdef OOB_WRAP_EN
    check("t4_count", 32'(log_addr.size()), 32'd5);
    check_log("t4_0", 0, 3'd1, 32'd30);
    check_log("t4_1", 1, 3'd0, 32'd31);
    check_log("t4_2", 2, 3'd2, 32'd32);
`else
    check("t4_count", 32'(log_addr.size()), 32'd3);
    check_log("t4_0", 0, 3'd1, 32'd30);
    check_log("t4_1", 1, 3'd2, 32'd32);
    check_log("t4_2", 2, 3'd3, 32'd34);
`endif
    check("t4_oob_count", 32'(oob_count), 32'd2);

    // 5: counter saturation
    for (int i = 0; i < 65534 - 2; i++) push(3'd7, 32'(i));
    drain();
    check("t5_pre", 32'(oob_count), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) push(3'd7, 32'(i));
    drain();
    check("t5_sat", 32'(oob_count), 32'h0000FFFF);

    // 6: reset discards buffered requests and the output slot
    clear_log();
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(3'(i + 1), 32'(40 + i));
    check("t6_wr_valid_pre", 32'(wr_valid), 32'd1);
    rst_n = 1'b0;
    step();
    check("t6_wr_valid", 32'(wr_valid), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_oob_count", 32'(oob_count), 32'd0);
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("t6_nothing_issued", 32'(log_addr.size()), 32'd0);
    check("t6_idle_after", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
